c5g_led_pio_blink: RTL and testbench
====================================

# c5g_led_pio_blink

Parametrised Avalon-MM output PIO for the Cyclone V GX Starter Kit LED banks, the successor to the fixed 10-bit LED PIO in the Qsys system. It adds a configurable width, a configurable reset value, atomic set/clear registers and a per-bit hardware blink engine driven by a programmable prescaler. The block sits on the Nios II data master as a zero-wait-state slave, and `out_port` drives board LEDs directly.

## Interface
- `WIDTH`, 10: number of output bits, legal range 1..32.
- `PRESC_W`, 24: width of the blink prescaler period and counter, legal range 1..32.
- `RESET_VALUE`, 0: value loaded into the data register at reset (WIDTH bits).
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `address` in 3: word address.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data.
- `readdata` out 32: read data, combinational from `address`.
- `out_port` out WIDTH: LED drive.

## Operation
- A write is accepted on a rising edge when `chipselect` is 1 and `write_n` is 0. Unused `writedata` bits are ignored. Reads have no side effects.
- Register map:
  - 0 DATA (rw): `data[WIDTH-1:0]`.
  - 1 MODE (rw): `mode[WIDTH-1:0]`. A bit set to 1 marks that bit as blinking.
  - 2 PERIOD (rw): `period[PRESC_W-1:0]`.
  - 3 STATUS (ro): bit0 is `phase`; all other bits read 0.
  - 4 OUTSET (wo): `data <= data | writedata[WIDTH-1:0]`.
  - 5 OUTCLEAR (wo): `data <= data & ~writedata[WIDTH-1:0]`.
  - 6 and 7: reserved. Writes are ignored.
- Addresses 4..7 read 0. Readback is zero-extended to 32 bits.
- `out_port = data & (~mode | {WIDTH{phase}})`. Static bits follow `data`; blinking bits show `data` gated by `phase`.
- Blink engine: down-counter `cnt` (PRESC_W bits).
  - If `period == 0`: `cnt` is held at 0 and `phase` is held at 1, so blinking bits behave as static.
  - Else, if `cnt == 0`: `cnt <= period` and `phase <= ~phase`.
  - Else: `cnt <= cnt - 1`.
  - Resulting half-period is `period + 1` clocks; full blink period is `2*(period + 1)`.
- A write to PERIOD loads `period` and also sets `cnt <= new value`. `phase` is unchanged. This write overrides the engine update in that cycle.
- A write to MODE does not disturb `cnt` or `phase`. If a phase toggle happens in the same cycle, both take effect.
- Reset values: `data = RESET_VALUE`, `mode = 0`, `period = 0`, `cnt = 0`, `phase = 1`. At reset `out_port` = RESET_VALUE and `readdata` = the register selected by `address`.
- Reset asserted mid-blink returns all of the above state on the next edge, regardless of any simultaneous write.

## Timing
- Write to visible effect: the register updates on the accepting edge. `out_port` (combinational from registers) reflects the new value immediately after that edge, i.e. latency 1 clock from the write-strobe cycle.
- Read: 0 wait states. `readdata` is valid in the same cycle as `address`.
- Phase toggles occur exactly every `period + 1` clocks after a PERIOD write, with the first toggle `period + 1` edges after the write edge.
- No backpressure. Every addressed access completes in one cycle.

## Configuration
- `C5G_LED_PIO_BLINK_EN` defined:
  - Blink engine, MODE, PERIOD and STATUS are implemented as described above.
- `C5G_LED_PIO_BLINK_EN` undefined:
  - No prescaler or phase logic is built.
  - Addresses 1, 2 and 3 read 0, and writes to them are ignored.
  - `out_port = data`.
  - DATA, OUTSET and OUTCLEAR behave identically to the defined build.

## Test plan
- Reset: assert `reset` 2 cycles with WIDTH=10 and RESET_VALUE=10'h155 -> `out_port` = 10'h155; reads of address 0 = 32'h155, address 1 = 0, address 3 = 1.
- Set/clear: write DATA=10'h0F0, then OUTSET=10'h00F, then OUTCLEAR=10'h0C0 -> `out_port` sequence 0x0F0, 0x0FF, 0x03F, each visible after its write edge; address 4 reads 0.
- Blink: DATA=10'h3FF, MODE=10'h001, PERIOD=3 -> bit0 toggles every 4 clocks (low 4 clocks, high 4 clocks); bits 9..1 stay 1; STATUS bit0 tracks bit0.
- Period boundary: while blinking, write PERIOD=0 -> `phase` freezes at its current value, then is forced to 1 on the next edge, so bit0 = 1 steady. Write PERIOD=1 -> toggle every 2 clocks.
- Mid-operation reset: assert `reset` in the same cycle as a write of DATA=0 during blinking -> all registers return to reset values; the write is discarded.
- Macro off: rebuild without `C5G_LED_PIO_BLINK_EN`, write MODE=10'h3FF and PERIOD=1 -> reads of addresses 1..3 return 0; `out_port` equals DATA with no toggling over 100 clocks.

Source files
------------

// File: rtl/c5g_led_pio_blink.sv
// rtl/c5g_led_pio_blink.sv - Avalon-MM LED output PIO with set/clear and per-bit blink (blink engine under `C5G_LED_PIO_BLINK_EN)
module c5g_led_pio_blink #(
  parameter int               WIDTH       = 10,
  parameter int               PRESC_W     = 24,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic             wr_en;
  logic [WIDTH-1:0] wr_bits;
  logic [WIDTH-1:0] data;
  logic             unused_ok;

  assign wr_en     = chipselect && !write_n;
  assign wr_bits   = writedata[WIDTH-1:0];
  // Upper writedata bits are legitimately ignored for narrow configurations.
  assign unused_ok = &{1'b0, writedata};

  // DATA register: direct write plus atomic set/clear aliases.
  always_ff @(posedge clk) begin
    if (reset) begin
      data <= RESET_VALUE;
    end else if (wr_en) begin
      case (address)
        3'd0:    data <= wr_bits;
        3'd4:    data <= data | wr_bits;
        3'd5:    data <= data & ~wr_bits;
        default: data <= data;
      endcase
    end
  end

`ifdef C5G_LED_PIO_BLINK_EN
  logic [WIDTH-1:0]   mode;
  logic [PRESC_W-1:0] period;
  logic [PRESC_W-1:0] cnt;
  logic               phase;

  // MODE register: selects which bits are gated by the blink phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode <= '0;
    end else if (wr_en && address == 3'd1) begin
      mode <= wr_bits;
    end
  end

  // Prescaler and phase: a PERIOD write reloads the counter and wins over the engine.
  always_ff @(posedge clk) begin
    if (reset) begin
      period <= '0;
      cnt    <= '0;
      phase  <= 1'b1;
    end else if (wr_en && address == 3'd2) begin
      period <= writedata[PRESC_W-1:0];
      cnt    <= writedata[PRESC_W-1:0];
    end else if (period == '0) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == '0) begin
      cnt   <= period;
      phase <= ~phase;
    end else begin
      cnt <= cnt - PRESC_W'(1);
    end
  end

  // Static bits follow data; blinking bits are additionally gated by phase.
  assign out_port = data & (~mode | {WIDTH{phase}});

  // Zero-wait-state readback, zero-extended.
  always_comb begin
    readdata = '0;
    case (address)
      3'd0:    readdata = 32'(data);
      3'd1:    readdata = 32'(mode);
      3'd2:    readdata = 32'(period);
      3'd3:    readdata = {31'b0, phase};
      default: readdata = '0;
    endcase
  end
`else
  assign out_port = data;

  // Without the blink engine only DATA is readable.
  always_comb begin
    readdata = '0;
    if (address == 3'd0) begin
      readdata = 32'(data);
    end
  end
`endif

endmodule

// File: tb/tb_c5g_led_pio_blink.sv
// tb/tb_c5g_led_pio_blink.sv - self-checking bench for c5g_led_pio_blink
module tb_c5g_led_pio_blink;

  localparam int         W   = 10;
  localparam int         PW  = 24;
  localparam logic [9:0] RV  = 10'h155;
`ifdef C5G_LED_PIO_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [W-1:0] out_port;

  int n_pass;
  int n_total;

  // Reference model: registers plus "phase at the last PERIOD write" and edges since.
  logic [W-1:0]  m_data;
  logic [W-1:0]  m_mode;
  logic [PW-1:0] m_period;
  logic          m_phase0;
  int            m_k;

  c5g_led_pio_blink #(
    .WIDTH(W),
    .PRESC_W(PW),
    .RESET_VALUE(RV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  function automatic logic model_phase();
    int half;
    if (!BLINK) return 1'b1;
    if (m_period == '0) return (m_k == 0) ? m_phase0 : 1'b1;
    half = int'(m_period) + 1;
    return m_phase0 ^ logic'((m_k / half) % 2);
  endfunction

  function automatic logic [W-1:0] model_out();
    logic [W-1:0] r;
    logic ph;
    ph = model_phase();
    for (int b = 0; b < W; b++)
      r[b] = m_mode[b] ? (m_data[b] & ph) : m_data[b];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return {22'b0, m_data};
      3'd1: return BLINK ? {22'b0, m_mode} : 32'd0;
      3'd2: return BLINK ? {8'b0, m_period} : 32'd0;
      3'd3: return BLINK ? {31'b0, model_phase()} : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Apply the rules of one rising edge to the model, using the inputs held in that cycle.
  task automatic model_edge();
    logic cur;
    if (reset) begin
      m_data = RV; m_mode = '0; m_period = '0; m_phase0 = 1'b1; m_k = 0;
    end else begin
      cur = model_phase();
      m_k++;
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_data = writedata[W-1:0];
          3'd1: if (BLINK) m_mode = writedata[W-1:0];
          3'd2: if (BLINK) begin m_period = writedata[PW-1:0]; m_phase0 = cur; m_k = 0; end
          3'd4: m_data = m_data | writedata[W-1:0];
          3'd5: m_data = m_data & ~writedata[W-1:0];
          default: ;
        endcase
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h t=%0t", tag, got, exp, $time);
  endtask

  task automatic check_out(input string tag);
    check(tag, {22'b0, out_port}, {22'b0, model_out()});
  endtask

  task automatic check_reads(input string tag);
    write_n = 1'b1;
    chipselect = 1'b0;
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      check($sformatf("%s_rd%0d", tag, a), readdata, model_read(3'(a)));
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    m_data = '0; m_mode = '0; m_period = '0; m_phase0 = 1'b1; m_k = 0;
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;

    // Reset for two cycles: RESET_VALUE on the LEDs, STATUS phase = 1.
    step(); step();
    reset = 1'b0;
    check("reset_out", {22'b0, out_port}, 32'h155);
    check_reads("reset");

    // Set/clear sequence.
    wr(3'd0, 32'hFFFF_F0F0);
    check("set_data", {22'b0, out_port}, 32'h0F0);
    wr(3'd4, 32'h0000_000F);
    check("outset", {22'b0, out_port}, 32'h0FF);
    wr(3'd5, 32'h0000_00C0);
    check("outclear", {22'b0, out_port}, 32'h03F);
    check_reads("setclr");

    // Blink bit0 with PERIOD=3; also the macro-off path where nothing toggles.
    wr(3'd0, 32'h3FF);
    wr(3'd1, 32'h001);
    wr(3'd2, 32'd3);
    for (int i = 0; i < 20; i++) begin
      check_out("blink_p3");
      check_reads("blink_p3");
      step();
    end

    // Period boundary: PERIOD=0 freezes then forces phase to 1; PERIOD=1 toggles every 2.
    wr(3'd2, 32'd0);
    for (int i = 0; i < 6; i++) begin
      check_out("period0");
      step();
    end
    wr(3'd2, 32'd1);
    for (int i = 0; i < 10; i++) begin
      check_out("period1");
      address = 3'd3; #1;
      check("period1_status", readdata, model_read(3'd3));
      step();
    end

    // Mid-operation reset collides with a DATA=0 write; the write is discarded.
    wr(3'd2, 32'd2);
    step(); step();
    reset = 1'b1;
    wr(3'd0, 32'h0);
    reset = 1'b0;
    check("midreset_out", {22'b0, out_port}, 32'h155);
    check_reads("midreset");

    // Macro-off style: MODE all ones and PERIOD=1, run 100 clocks.
    wr(3'd1, 32'h3FF);
    wr(3'd2, 32'd1);
    for (int i = 0; i < 100; i++) begin
      check_out("long_run");
      step();
    end

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 300; i++) begin
      address    = 3'($urandom_range(0, 7));
      chipselect = 1'($urandom_range(0, 3) != 0);
      write_n    = 1'($urandom_range(0, 2) == 0);
      writedata  = (address == 3'd2) ? 32'($urandom_range(0, 5)) : $urandom;
      reset      = ($urandom_range(0, 49) == 0);
      step();
      reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
      check_out("rand_out");
      address = 3'($urandom_range(0, 7)); #1;
      check("rand_rd", readdata, model_read(address));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
